// File: rtl/mine_map_gen_if.sv
// ============================================================================
//  mine_map_gen_if
//  Request/result bundle between the game controller and mine_map_gen.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface mine_map_gen_if #(
    parameter int MAP_WIDTH  = 8,
    parameter int MAP_HEIGHT = 8
);
    logic                            start_i;
    logic [7:0]                      safe_pos_i;
    logic [MAP_WIDTH*MAP_HEIGHT-1:0] map_o;
    logic                            busy_o;
    logic                            done_o;
    logic                            map_valid_o;

    modport master (
        output start_i,
        output safe_pos_i,
        input  map_o,
        input  busy_o,
        input  done_o,
        input  map_valid_o
    );

    modport slave (
        input  start_i,
        input  safe_pos_i,
        output map_o,
        output busy_o,
        output done_o,
        output map_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/mine_map_gen.sv
// ============================================================================
//  mine_map_gen
//  LFSR-driven placement of MINE_NUM distinct mines, avoiding the safe cell.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mine_map_gen #(
    parameter int          MAP_WIDTH  = 8,
    parameter int          MAP_HEIGHT = 8,
    parameter int          MINE_NUM   = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mine_map_gen_if.slave      bus
);

    localparam int          C_CELLS   = MAP_WIDTH * MAP_HEIGHT;
    localparam int          C_CB      = $clog2(C_CELLS);
    localparam int          C_CNT_W   = (MINE_NUM > 0) ? $clog2(MINE_NUM + 1) : 1;
    localparam logic [31:0] C_CELLS_U = C_CELLS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_PLACE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [15:0]        r_lfsr;
    logic [1:0]         r_state;
    logic [C_CELLS-1:0] r_map;
    logic [C_CNT_W-1:0] r_cnt;
    logic [7:0]         r_safe;
    logic               r_valid;

    logic               w_fb;
    logic [C_CB-1:0]    w_cand;
    logic [31:0]        w_cand_ext;
    logic               w_hit;
    logic [C_CNT_W-1:0] w_cnt_nxt;

    // Taps at 16,14,13,11: the register runs through all non-zero states
    assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_cand     = r_lfsr[C_CB-1:0];
    assign w_cand_ext = {{(32-C_CB){1'b0}}, w_cand};
    assign w_hit      = (w_cand_ext < C_CELLS_U)
                     && (w_cand_ext != {24'd0, r_safe})
                     && !r_map[w_cand];
    assign w_cnt_nxt  = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr  <= LFSR_SEED;
            r_state <= S_IDLE;
            r_map   <= '0;
            r_cnt   <= '0;
            r_safe  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_safe  <= bus.safe_pos_i;
                        r_valid <= 1'b0;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_map <= '0;
                    r_cnt <= '0;
                    if (MINE_NUM == 0) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    if (w_hit) begin
                        r_map[w_cand] <= 1'b1;
                        r_cnt         <= w_cnt_nxt;
                        if (w_cnt_nxt == C_CNT_W'(MINE_NUM)) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Valid rises together with the done pulse so the map is usable from that cycle on
    assign bus.map_o       = r_map;
    assign bus.busy_o      = (r_state == S_CLEAR) || (r_state == S_PLACE);
    assign bus.done_o      = (r_state == S_DONE);
    assign bus.map_valid_o = r_valid;

endmodule

`default_nettype wire
